// File: rtl/me_frame_loader.sv
// Host-side loader for the motion estimator: buffers the reference block and search window,
// starts the estimator, times the run and hands the motion vector back. Optional: ME_LOAD_CHECKSUM_EN.
module me_frame_loader #(
    parameter int unsigned RUN_CYCLES = 32'd4112
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       result_valid,
    input  logic       result_ack,
    output logic [3:0] result_x,
    output logic [3:0] result_y,
    output logic       me_start,
    input  logic [7:0] AddressR,
    input  logic [9:0] AddressS1,
    input  logic [9:0] AddressS2,
    output logic [7:0] me_R,
    output logic [7:0] me_s1,
    output logic [7:0] me_s2,
    input  logic [3:0] motionx,
    input  logic [3:0] motiony
`ifdef ME_LOAD_CHECKSUM_EN
    ,
    output logic [15:0] load_sum
`endif
);

    localparam int unsigned R_BYTES = 256;
    localparam int unsigned S_BYTES = 1024;
    localparam int unsigned R_AW    = $clog2(R_BYTES);
    localparam int unsigned S_AW    = $clog2(S_BYTES);
    localparam int unsigned LOAD_W  = $clog2(R_BYTES + S_BYTES);
    localparam int unsigned RUN_W   = (RUN_CYCLES > 2) ? $clog2(RUN_CYCLES) : 1;

    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(R_BYTES + S_BYTES - 1);
    localparam logic [LOAD_W-1:0] R_LIMIT   = LOAD_W'(R_BYTES);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              me_start_q, me_start_d;
    logic              result_valid_q, result_valid_d;
    logic [3:0]        result_x_q, result_x_d;
    logic [3:0]        result_y_q, result_y_d;
    logic              accept;

    logic [7:0] rmem [R_BYTES];
    logic [7:0] smem [S_BYTES];

    assign accept = in_valid && (state_q == ST_LOAD);

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        run_cnt_d  = run_cnt_q;
        result_x_d = result_x_q;
        result_y_d = result_y_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
            end
            ST_START: begin
                run_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (run_cnt_q == RUN_LAST) begin
                    result_x_d = motionx;
                    result_y_d = motiony;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        in_ready_d     = (state_d == ST_LOAD);
        busy_d         = (state_d != ST_LOAD);
        me_start_d     = (state_d == ST_START);
        result_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_LOAD;
            load_cnt_q     <= '0;
            run_cnt_q      <= '0;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            me_start_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_x_q     <= '0;
            result_y_q     <= '0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            run_cnt_q      <= run_cnt_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            me_start_q     <= me_start_d;
            result_valid_q <= result_valid_d;
            result_x_q     <= result_x_d;
            result_y_q     <= result_y_d;
        end
    end

    // Storage keeps its contents across reset; a new load simply overwrites it
    always_ff @(posedge clock) begin
        if (accept) begin
            if (load_cnt_q < R_LIMIT) begin
                rmem[R_AW'(load_cnt_q)] <= in_data;
            end else begin
                smem[S_AW'(load_cnt_q - R_LIMIT)] <= in_data;
            end
        end
    end

    assign me_R  = rmem[AddressR];
    assign me_s1 = smem[AddressS1];
    assign me_s2 = smem[AddressS2];

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign me_start     = me_start_q;
    assign result_valid = result_valid_q;
    assign result_x     = result_x_q;
    assign result_y     = result_y_q;

`ifdef ME_LOAD_CHECKSUM_EN
    logic [15:0] load_sum_q, load_sum_d;

    // Running sum restarts on the first byte of each load
    always_comb begin
        load_sum_d = load_sum_q;
        if (accept) begin
            load_sum_d = ((load_cnt_q == '0) ? 16'(0) : load_sum_q) + 16'(in_data);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            load_sum_q <= '0;
        end else begin
            load_sum_q <= load_sum_d;
        end
    end

    assign load_sum = load_sum_q;
`endif

endmodule
